// File: rtl/tpu_pkg.sv
// Shared TPU definitions: datapath sizes, weight-fetch FSM encoding and row type.
package tpu_pkg;

    // Weight memory address width
    localparam int unsigned ADDR_W    = 13;
    // Width of one weight
    localparam int unsigned DATA_W    = 16;
    // Weights per row, max rows per load, address stride per row
    localparam int unsigned ARRAY_DIM = 4;

    // Width of the row index presented to the array
    localparam int unsigned ROW_IDX_W = $clog2(ARRAY_DIM);
    // Width of the row-count request (0..ARRAY_DIM)
    localparam int unsigned ROWS_W    = 3;
    // Range check is done with headroom so base + rows*stride cannot wrap
    localparam int unsigned CHK_W     = ADDR_W + 3;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StPresent,
        StDone
    } wfetch_state_t;

    // One row of weights, element 0 in the least significant bits
    typedef logic [ARRAY_DIM-1:0][DATA_W-1:0] weight_row_t;

    // A load is legal when the row count fits the array and the last weight
    // address stays inside the memory (no wrap-around).
    function automatic logic load_req_ok(input logic [ADDR_W-1:0] base,
                                         input logic [ROWS_W-1:0] rows);
        logic [CHK_W-1:0] end_excl;
        end_excl = CHK_W'(base) + (CHK_W'(rows) * CHK_W'(ARRAY_DIM));
        return (CHK_W'(rows) <= CHK_W'(ARRAY_DIM)) &&
               (end_excl <= (CHK_W'(1) << ADDR_W));
    endfunction

endpackage

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: reads weight rows from the weight memory and hands them
// to the systolic array's weight-load port with a valid/ready handshake.
module weight_fetch_ctrl
    import tpu_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ROWS_W-1:0]             num_rows,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd_en,
    input  logic [ARRAY_DIM*DATA_W-1:0]   mem_rdata,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [ROW_IDX_W-1:0]          row_idx,
    output logic [ARRAY_DIM*DATA_W-1:0]   load_w
);

    wfetch_state_t          state_q, state_d;
    logic                   err_q, err_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [ROWS_W-1:0]      num_rows_q, num_rows_d;
    logic [ROWS_W-1:0]      row_cnt_q, row_cnt_d;
    logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
    weight_row_t            load_q, load_d;

    logic                   last_row;

    assign last_row = (row_cnt_q == (num_rows_q - ROWS_W'(1)));

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        mem_addr_d = mem_addr_q;
        num_rows_d = num_rows_q;
        row_cnt_d  = row_cnt_q;
        row_idx_d  = row_idx_q;
        load_d     = load_q;

        busy       = 1'b0;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        row_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (!load_req_ok(base_addr, num_rows)) begin
                        err_d = 1'b1;
                    end else if (num_rows == '0) begin
                        num_rows_d = '0;
                        state_d    = StDone;
                    end else begin
                        num_rows_d = num_rows;
                        mem_addr_d = base_addr;
                        row_cnt_d  = '0;
                        state_d    = StRead;
                    end
                end
            end
            StRead: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                busy = 1'b1;
                // Read data for mem_addr arrives this cycle
                load_d    = weight_row_t'(mem_rdata);
                row_idx_d = row_cnt_q[ROW_IDX_W-1:0];
                state_d   = StPresent;
            end
            StPresent: begin
                busy      = 1'b1;
                row_valid = 1'b1;
                if (row_ready) begin
                    row_cnt_d = row_cnt_q + ROWS_W'(1);
                    if (last_row) begin
                        state_d = StDone;
                    end else begin
                        // Safe: the start range check keeps the last row in bounds
                        mem_addr_d = mem_addr_q + ADDR_W'(ARRAY_DIM);
                        state_d    = StRead;
                    end
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            row_idx_q  <= '0;
            load_q     <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            num_rows_q <= num_rows_d;
            row_cnt_q  <= row_cnt_d;
            row_idx_q  <= row_idx_d;
            load_q     <= load_d;
        end
    end

    assign err      = err_q;
    assign mem_addr = mem_addr_q;
    assign row_idx  = row_idx_q;
    assign load_w   = load_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl with a behavioural load model.
module tb_weight_fetch_ctrl;
    import tpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [2:0]  num_rows;
    logic        busy, done, err;
    logic [12:0] mem_addr;
    logic        mem_rd_en;
    logic [63:0] mem_rdata;
    logic        row_valid;
    logic        row_ready;
    logic [1:0]  row_idx;
    logic [63:0] load_w;

    weight_fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_idx   (row_idx),
        .load_w    (load_w)
    );

    always #5 clk = ~clk;

    // Weight memory: 4-wide registered read, 1-cycle latency
    logic [15:0] mem [0:8191];
    always @(posedge clk)
        mem_rdata <= {mem[(mem_addr + 13'd3)], mem[(mem_addr + 13'd2)],
                      mem[(mem_addr + 13'd1)], mem[mem_addr]};

    // kind: 0 = row handshake, 1 = done pulse, 2 = err pulse
    typedef struct {
        int          kind;
        logic [63:0] data;
        logic [1:0]  idx;
        logic [12:0] addr;
    } ev_t;
    ev_t expq[$];

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what a start request should produce, from the load rules
    task automatic push_load(input int base, input int n);
        ev_t e;
        if (n > 4 || (n != 0 && base + 4 * n > 8192)) begin
            e.kind = 2; e.data = '0; e.idx = '0; e.addr = '0;
            expq.push_back(e);
        end else begin
            for (int r = 0; r < n; r++) begin
                int a;
                a = base + 4 * r;
                e.kind = 0;
                e.addr = 13'(a);
                e.idx  = 2'(r);
                e.data = {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
                expq.push_back(e);
            end
            e.kind = 1; e.data = '0; e.idx = '0; e.addr = '0;
            expq.push_back(e);
        end
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = expq.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            if (kind == 0 && e.kind == 0) begin
                check("row_data", load_w, e.data);
                check("row_idx", 64'(row_idx), 64'(e.idx));
                check("row_addr", 64'(mem_addr), 64'(e.addr));
            end
        end
    endtask

    // Array-side ready driver
    initial begin
        row_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: row_ready = 1'b1;
                1: row_ready = 1'($urandom % 2);
                default: begin
                    if (row_valid && row_idx == 2'd1 && stall_cnt < 5) begin
                        row_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        row_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: observes handshakes and pulses, compares against the scoreboard
    initial begin
        logic        stall_prev;
        logic [63:0] prev_w;
        logic [1:0]  prev_idx;
        logic [12:0] prev_addr;
        stall_prev = 1'b0;
        prev_w = '0; prev_idx = '0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(row_valid), 64'd1);
                    check("stall_data", load_w, prev_w);
                    check("stall_idx", 64'(row_idx), 64'(prev_idx));
                    check("stall_addr", 64'(mem_addr), 64'(prev_addr));
                end
                stall_prev = row_valid && !row_ready;
                prev_w = load_w; prev_idx = row_idx; prev_addr = mem_addr;
                if (row_valid && row_ready) pop_cmp(0);
                if (done) pop_cmp(1);
                if (err) begin
                    pop_cmp(2);
                    check("err_busy", 64'(busy), 64'd0);
                end
            end
        end
    end

    // Issue one start and wait for its done/err; cyc = cycle of done/err after the start edge
    task automatic do_load(input int base, input int n, input int mode, input bit intrude,
                           output int cyc);
        bit fin;
        bit intruded;
        @(posedge clk);
        #1;
        ready_mode = mode;
        stall_cnt  = 0;
        start      = 1'b1;
        base_addr  = 13'(base);
        num_rows   = 3'(n);
        push_load(base, n);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        fin = 1'b0;
        intruded = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(negedge clk);
            cyc++;
            if (done || err) begin
                fin = 1'b1;
            end else if (intrude && row_valid && !intruded) begin
                // Second start while busy must be ignored
                start     = 1'b1;
                base_addr = 13'(base) ^ 13'h0400;
                num_rows  = 3'd2;
                intruded  = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got no done/err expected one within 300 cycles");
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_err"}, 64'(err), 64'd0);
        check({name, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({name, "_valid"}, 64'(row_valid), 64'd0);
        check({name, "_addr"}, 64'(mem_addr), 64'd0);
        check({name, "_idx"}, 64'(row_idx), 64'd0);
        check({name, "_load_w"}, load_w, 64'd0);
    endtask

    initial begin
        int cyc;
        bit found;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_rows = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[16'h000F] = 16'd3; mem[16'h0010] = 16'd5;
        mem[16'h0011] = 16'd4; mem[16'h0012] = 16'd6;
        for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'(16'h0100 + i);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Basic single-row load: expected row {6,4,5,3}
        do_load(16'h000F, 1, 0, 1'b0, cyc);
        check("basic_cycles", 64'(cyc), 64'd4);

        // Full 4-row load with no stall: done in cycle 13
        do_load(16'h0100, 4, 0, 1'b0, cyc);
        check("full_cycles", 64'(cyc), 64'd13);

        // Backpressure on row 1 for 5 cycles delays done by 5
        do_load(16'h0100, 4, 2, 1'b0, cyc);
        check("stall_cycles", 64'(cyc), 64'd18);

        // Rejects and edge cases
        do_load(16'h0100, 5, 0, 1'b0, cyc);
        check("rej_rows_cycles", 64'(cyc), 64'd1);
        do_load(16'h1FFE, 1, 0, 1'b0, cyc);
        check("rej_range_cycles", 64'(cyc), 64'd1);
        do_load(16'h1FFC, 1, 0, 1'b0, cyc);
        check("top_row_cycles", 64'(cyc), 64'd4);
        do_load(16'h1FF1, 4, 0, 1'b0, cyc);
        check("rej_range4_cycles", 64'(cyc), 64'd1);
        do_load(16'h1FF0, 4, 0, 1'b0, cyc);
        check("top_full_cycles", 64'(cyc), 64'd13);
        do_load(16'h0000, 0, 0, 1'b0, cyc);
        check("zero_rows_cycles", 64'(cyc), 64'd1);

        // Start while busy is ignored
        do_load(16'h0200, 3, 1, 1'b1, cyc);

        // Reset during PRESENT of row 2
        @(posedge clk);
        #1;
        ready_mode = 0;
        start = 1'b1;
        base_addr = 13'h0100;
        num_rows = 3'd4;
        push_load(16'h0100, 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (row_valid && row_idx == 2'd2) found = 1'b1;
        end
        check("reach_row2", 64'(found), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        expq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_load(16'h0100, 4, 0, 1'b0, cyc);
        check("post_reset_cycles", 64'(cyc), 64'd13);

        // Randomized loads, biased toward the top of memory for range checks
        for (int k = 0; k < 25; k++) begin
            int b;
            int n;
            b = int'($urandom_range(0, 8191));
            if ($urandom % 4 == 0) b = 8192 - int'($urandom_range(1, 20));
            n = int'($urandom_range(0, 5));
            do_load(b, n, 1, 1'($urandom % 2), cyc);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
